mem_interface: RTL and testbench

MEM_INTERFACE -- requirements
Module: mem_interface

---
 rtl/mem_interface.sv | 143 ++++++++++++++
 tb/tb_mem_interface.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_interface.sv
// Load/store unit bus adapter: aligns addresses, builds byte enables and lane-replicated
// store data, runs a single outstanding bus access with ack timeout, and extends load data.
module mem_interface #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mem_read_op,
    input  logic [1:0]  mem_write_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
    typedef struct packed {
        logic       is_load;
        logic       sext;
        size_t      size;
        logic [1:0] lane;
    } req_t;

    state_t        state;
    req_t          req;
    logic [CW-1:0] cnt;
    logic          rd_act, wr_act, aligned;
    size_t         size;
    logic [3:0]    be;
    logic [31:0]   wrep, ld_val;
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;

    // Decode the presented op; a valid read masks any simultaneous write.
    always_comb begin
        rd_act = mem_read_op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        wr_act = !rd_act && (mem_write_op != 2'b11);
        size   = SZ_B;
        if (rd_act) begin
            case (mem_read_op[1:0])
                2'b01:   size = SZ_H;
                2'b10:   size = SZ_W;
                default: size = SZ_B;
            endcase
        end else begin
            case (mem_write_op)
                2'b01:   size = SZ_H;
                2'b10:   size = SZ_W;
                default: size = SZ_B;
            endcase
        end
        case (size)
            SZ_H: begin
                aligned = !addr[0];
                be      = 4'b0011 << {addr[1], 1'b0};
                wrep    = {2{wdata[15:0]}};
            end
            SZ_W: begin
                aligned = (addr[1:0] == 2'b00);
                be      = 4'b1111;
                wrep    = wdata;
            end
            default: begin
                aligned = 1'b1;
                be      = 4'b0001 << addr[1:0];
                wrep    = {4{wdata[7:0]}};
            end
        endcase
    end

    always_comb begin
        ld_b = bus_rdata[{req.lane, 3'b000} +: 8];
        ld_h = bus_rdata[{req.lane[1], 4'b0000} +: 16];
        case (req.size)
            SZ_B:    ld_val = {{24{req.sext & ld_b[7]}}, ld_b};
            SZ_H:    ld_val = {{16{req.sext & ld_h[15]}}, ld_h};
            default: ld_val = bus_rdata;
        endcase
    end

    assign stall   = !reset && ((state == BUSY) ||
                                (state == IDLE && (rd_act || wr_act) && aligned));
    assign bus_req = (state == BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req        <= '0;
            cnt        <= '0;
            rdata      <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_act || wr_act) begin
                        if (aligned) begin
                            state     <= BUSY;
                            cnt       <= '0;
                            bus_we    <= wr_act;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= be;
                            bus_wdata <= wrep;
                            req       <= '{is_load: rd_act, sext: !mem_read_op[2],
                                           size: size, lane: addr[1:0]};
                        end else begin
                            misaligned <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // A real ack beats a timeout landing in the same cycle.
                    if (bus_ack) begin
                        state <= DONE;
                        if (req.is_load) rdata <= ld_val;
                    end else if (cnt == CNT_LAST) begin
                        state   <= DONE;
                        bus_err <= 1'b1;
                        if (req.is_load) rdata <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: directed vector table, multi-cycle corner sequences,
// and random accesses checked against a behavioural model.
module tb_mem_interface;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  mem_read_op = 3'b111;
    logic [1:0]  mem_write_op = 2'b11;
    logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic        stall, misaligned, bus_err, bus_req, bus_we;
    logic [3:0]  bus_be;

    int errors = 0;
    int checks = 0;

    mem_interface #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .mem_read_op(mem_read_op), .mem_write_op(mem_write_op),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misaligned(misaligned),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    typedef struct {
        bit          req;
        int          stall_n;
        logic [3:0]  be;
        logic [31:0] ba, wd, rd;
        bit          we, mis, err;
    } exp_t;

    typedef struct {
        logic [2:0]  rop;
        logic [1:0]  wop;
        logic [31:0] a, wd, rw;
        int          dly;
        exp_t        e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Spec-level reference: sizes in bytes, offsets and masks with plain arithmetic.
    function automatic exp_t model(input logic [2:0] rop, input logic [1:0] wop,
                                   input logic [31:0] a, wd, rw, input int dly,
                                   input logic [31:0] prd, input bit pmis, input bit perr);
        exp_t e;
        bit rd, wr, to;
        int n, off;
        logic [63:0] v, m;
        e.req = 0; e.stall_n = 0; e.be = '0; e.ba = '0; e.wd = '0; e.we = 0;
        e.rd = prd; e.mis = pmis; e.err = perr;
        rd = rop inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        wr = !rd && (wop != 2'd3);
        n  = rd ? (1 << rop[1:0]) : (wr ? (1 << wop) : 0);
        if (n == 0) return e;
        off = int'(a[1:0]);
        if (off % n != 0) begin
            e.mis = 1;
            return e;
        end
        e.req = 1;
        e.we  = wr;
        e.ba  = a - 32'(off);
        e.be  = 4'(((1 << n) - 1) << off);
        for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = wd[8*(i % n) +: 8];
        to = (dly < 0) || (dly >= TO);
        e.stall_n = 1 + (to ? TO : dly + 1);
        if (to) e.err = 1;
        if (rd) begin
            if (to) e.rd = '0;
            else begin
                v = 64'(rw) >> (8 * off);
                m = (64'd1 << (8 * n)) - 64'd1;
                v = v & m;
                if (!rop[2] && n < 4 && v[8*n-1]) v = v | ~m;
                e.rd = v[31:0];
            end
        end
        return e;
    endfunction

    // Starts at a negedge with the DUT idle; returns after the DUT is idle again.
    task automatic run_access(input logic [2:0] rop, input logic [1:0] wop,
                              input logic [31:0] a, wd, rw, input int dly,
                              output int s_n, output int r_n, output logic [3:0] be,
                              output logic [31:0] ba, bwd, output logic we);
        bit fin = 0;
        mem_read_op = rop; mem_write_op = wop; addr = a; wdata = wd; bus_rdata = rw;
        r_n = 0; be = '0; ba = '0; bwd = '0; we = 0;
        #1 s_n = int'(stall);
        for (int c = 0; c < 20 && !fin; c++) begin
            @(negedge clk);
            if (bus_req) begin
                if (r_n == 0) begin be = bus_be; ba = bus_addr; bwd = bus_wdata; we = bus_we; end
                bus_ack = (r_n == dly);
                r_n++;
                if (stall) s_n++;
            end else begin
                if (stall) s_n++;
                fin = 1;
            end
        end
        if (!fin) s_n = -1;
        bus_ack = 0; mem_read_op = 3'b111; mem_write_op = 2'b11;
        @(negedge clk);
    endtask

    task automatic check_access(input string tag, input vec_t v);
        int s_n, r_n;
        logic [3:0] be;
        logic [31:0] ba, bwd;
        logic we;
        run_access(v.rop, v.wop, v.a, v.wd, v.rw, v.dly, s_n, r_n, be, ba, bwd, we);
        chk({tag, " stall_cycles"}, 32'(s_n), 32'(v.e.stall_n));
        chk({tag, " req_cycles"}, 32'(r_n), v.e.req ? 32'(v.e.stall_n - 1) : 32'd0);
        if (v.e.req) begin
            chk({tag, " bus_be"}, 32'(be), 32'(v.e.be));
            chk({tag, " bus_addr"}, ba, v.e.ba);
            chk({tag, " bus_we"}, 32'(we), 32'(v.e.we));
            if (v.e.we) chk({tag, " bus_wdata"}, bwd, v.e.wd);
        end
        chk({tag, " rdata"}, rdata, v.e.rd);
        chk({tag, " misaligned"}, 32'(misaligned), 32'(v.e.mis));
        chk({tag, " bus_err"}, 32'(bus_err), 32'(v.e.err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; mem_read_op = 3'b111; mem_write_op = 2'b11; bus_ack = 0;
        @(negedge clk);
        reset = 0;
    endtask

    function automatic vec_t mk(input logic [2:0] rop, input logic [1:0] wop,
                                input logic [31:0] a, wd, rw, input int dly, input bit req,
                                input int s_n, input logic [3:0] be, input logic [31:0] ba,
                                input logic [31:0] bwd, input logic [31:0] rd,
                                input bit we, input bit mis, input bit err);
        vec_t v;
        v.rop = rop; v.wop = wop; v.a = a; v.wd = wd; v.rw = rw; v.dly = dly;
        v.e.req = req; v.e.stall_n = s_n; v.e.be = be; v.e.ba = ba; v.e.wd = bwd;
        v.e.rd = rd; v.e.we = we; v.e.mis = mis; v.e.err = err;
        return v;
    endfunction

    vec_t tbl[11];
    vec_t rv;
    logic [31:0] m_rd;
    bit m_mis, m_err;

    initial begin
        tbl[0]  = mk(3'd0, 2'd3, 32'h1003, 32'h0, 32'h80FF_FF12, 0, 1, 2, 4'b1000, 32'h1000, 32'h0, 32'hFFFF_FF80, 0, 0, 0);
        tbl[1]  = mk(3'd7, 2'd1, 32'h2002, 32'h1234_ABCD, 32'h0, 3, 1, 5, 4'b1100, 32'h2000, 32'hABCD_ABCD, 32'h0, 1, 0, 0);
        tbl[2]  = mk(3'd2, 2'd3, 32'h0006, 32'h0, 32'h0, 0, 0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
        tbl[3]  = mk(3'd5, 2'd3, 32'h0000, 32'h0, 32'h0, -1, 1, 5, 4'b0011, 32'h0, 32'h0, 32'h0, 0, 0, 1);
        tbl[4]  = mk(3'd4, 2'd2, 32'h0001, 32'hFFFF_FFFF, 32'h0000_9A00, 0, 1, 2, 4'b0010, 32'h0, 32'h0, 32'h0000_009A, 0, 0, 0);
        tbl[5]  = mk(3'd1, 2'd3, 32'h0102, 32'h0, 32'h8001_0000, 1, 1, 3, 4'b1100, 32'h0100, 32'h0, 32'hFFFF_8001, 0, 0, 0);
        tbl[6]  = mk(3'd7, 2'd0, 32'h0013, 32'h0000_0055, 32'h0, 0, 1, 2, 4'b1000, 32'h0010, 32'h5555_5555, 32'h0, 1, 0, 0);
        tbl[7]  = mk(3'd3, 2'd3, 32'h0040, 32'h0, 32'h0, 0, 0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        tbl[8]  = mk(3'd2, 2'd3, 32'h0020, 32'h0, 32'hDEAD_BEEF, 3, 1, 5, 4'b1111, 32'h0020, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        tbl[9]  = mk(3'd6, 2'd1, 32'h0005, 32'h0, 32'h0, 0, 0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
        tbl[10] = mk(3'd0, 2'd3, 32'h0008, 32'h0, 32'h0000_007F, 2, 1, 4, 4'b0001, 32'h0008, 32'h0, 32'h0000_007F, 0, 0, 0);

        // Reset state, with a load held on the inputs while reset is high.
        @(negedge clk);
        mem_read_op = 3'b010; addr = 32'h44; bus_rdata = 32'h1357_9BDF;
        @(negedge clk);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst bus_req", 32'(bus_req), 32'd0);
        chk("rst bus_we", 32'(bus_we), 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst bus_addr", bus_addr, 32'd0);
        chk("rst bus_be", 32'(bus_be), 32'd0);
        chk("rst bus_wdata", bus_wdata, 32'd0);
        chk("rst misaligned", 32'(misaligned), 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        // First cycle after reset accepts the op.
        reset = 0;
        #1 chk("post-rst stall", 32'(stall), 32'd1);
        @(negedge clk);
        chk("post-rst bus_req", 32'(bus_req), 32'd1);
        bus_ack = 1;
        @(negedge clk);
        chk("post-rst done req", 32'(bus_req), 32'd0);
        chk("post-rst rdata", rdata, 32'h1357_9BDF);
        bus_ack = 0; mem_read_op = 3'b111;
        @(negedge clk);

        // Store after a load leaves rdata alone.
        rv = mk(3'd7, 2'd2, 32'h0080, 32'hA5A5_0F0F, 32'hFFFF_FFFF, 1, 1, 3, 4'b1111, 32'h80, 32'hA5A5_0F0F, 32'h1357_9BDF, 1, 0, 0);
        check_access("store-keeps-rdata", rv);

        // Reset in the second BUSY cycle abandons the access; a late ack is ignored.
        mem_read_op = 3'b010; addr = 32'h40; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("abort busy1 req", 32'(bus_req), 32'd1);
        @(negedge clk);
        chk("abort busy2 req", 32'(bus_req), 32'd1);
        reset = 1; mem_read_op = 3'b111;
        @(negedge clk);
        chk("abort req", 32'(bus_req), 32'd0);
        chk("abort stall", 32'(stall), 32'd0);
        chk("abort rdata", rdata, 32'd0);
        chk("abort bus_addr", bus_addr, 32'd0);
        chk("abort bus_be", 32'(bus_be), 32'd0);
        reset = 0; bus_ack = 1;
        @(negedge clk);
        chk("late ack req", 32'(bus_req), 32'd0);
        chk("late ack rdata", rdata, 32'd0);
        bus_ack = 0;
        @(negedge clk);

        // Misaligned is sticky across a good access; timeout after a load zeroes rdata.
        rv = mk(3'd1, 2'd3, 32'h0003, 32'h0, 32'h0, 0, 0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
        check_access("mis-first", rv);
        rv = mk(3'd2, 2'd3, 32'h0010, 32'h0, 32'h1111_2222, 0, 1, 2, 4'b1111, 32'h10, 32'h0, 32'h1111_2222, 0, 1, 0);
        check_access("mis-sticky", rv);
        rv = mk(3'd0, 2'd3, 32'h0011, 32'h0, 32'h0000_FF00, -1, 1, 5, 4'b0010, 32'h10, 32'h0, 32'h0, 0, 1, 1);
        check_access("timeout-clears", rv);
        do_reset();
        chk("reset clears mis", 32'(misaligned), 32'd0);
        chk("reset clears err", 32'(bus_err), 32'd0);

        for (int i = 0; i < 11; i++) begin
            do_reset();
            @(negedge clk);
            check_access($sformatf("vec%0d", i), tbl[i]);
        end

        m_rd = '0; m_mis = 0; m_err = 0;
        for (int i = 0; i < 160; i++) begin
            if (i % 40 == 0) begin
                do_reset();
                @(negedge clk);
                m_rd = '0; m_mis = 0; m_err = 0;
            end
            rv.rop = 3'($urandom_range(0, 7));
            rv.wop = 2'($urandom_range(0, 3));
            rv.a   = $urandom;
            if ($urandom_range(0, 3) != 0) rv.a[0] = 1'b0;
            if ($urandom_range(0, 2) != 0) rv.a[1] = 1'b0;
            rv.wd  = $urandom;
            rv.rw  = $urandom;
            rv.dly = int'($urandom_range(0, 6)) - 1;
            rv.e   = model(rv.rop, rv.wop, rv.a, rv.wd, rv.rw, rv.dly, m_rd, m_mis, m_err);
            check_access($sformatf("rnd%0d", i), rv);
            m_rd = rv.e.rd; m_mis = rv.e.mis; m_err = rv.e.err;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
